// File: rtl/screen_scanout_pkg.sv
// Shared screen constants and the per-position flag bundle used by the scan-out pipeline.
// Latency: none (declarations only).
// Backpressure: none; this package only declares constants and types.
package screen_scanout_pkg;

  // Screen region location and size inside data memory.
  localparam logic [14:0] SCREEN_BASE   = 15'h4000;
  localparam int          SCREEN_WORDS  = 8192;
  localparam int          WORDS_PER_ROW = 32;

  // Default raster timing: 576 clocks per line, 264 lines per frame.
  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BACK   = 16;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_FRONT  = 2;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 2;

  // Decoded attributes of one raster position, carried down the pipeline.
  typedef struct packed {
    logic vis;  // visible pixel
    logic hs;   // inside hsync window
    logic vs;   // inside vsync window
    logic fs;   // position (0,0)
  } scan_flags_t;

endpackage

// File: rtl/screen_scanout_if.sv
// Screen RAM read port plus video output bundle of the scan-out engine.
// Latency: rdata is expected exactly one clock after rd_en.
// Backpressure: none; the slave side must always answer a read on time.
interface screen_scanout_if;

  logic [12:0] raddr;
  logic        rd_en;
  logic [15:0] rdata;
  logic        pixel;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  // Scan-out engine side.
  modport master (
    output raddr, rd_en, pixel, active, hsync, vsync, frame_start,
    input  rdata
  );

  // Memory / display side.
  modport slave (
    input  raddr, rd_en, pixel, active, hsync, vsync, frame_start,
    output rdata
  );

endinterface

// File: rtl/scan_timing.sv
// Raster h/v counters with visible, sync and frame-origin decode.
// Latency: flags are registered alongside the counters; next-position decode is combinational.
// Backpressure: none; free-running once out of reset.
module scan_timing
  import screen_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic        clock,
  input  logic        reset,
  output logic        o_fetch_nxt,   // next position starts a 16-pixel word
  output logic        o_origin_nxt,  // next position is (0,0)
  output scan_flags_t o_flags        // flags of the current position
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_B  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYN_E  = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN_B  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYN_E  = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic              r_started;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [HW-1:0]     w_h_nxt;
  logic [VW-1:0]     w_v_nxt;
  scan_flags_t       r_flags;
  scan_flags_t       w_flags_nxt;

  // Next raster position: the first edge out of reset lands on (0,0) so its fetch is not skipped.
  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (!r_started) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (r_h == H_LAST) begin
      w_h_nxt = '0;
      w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      w_h_nxt = r_h + 1'b1;
    end
  end

  // Decode of the next position, registered below so flags line up with the counters.
  always_comb begin
    w_flags_nxt.vis = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
    w_flags_nxt.hs  = (w_h_nxt >= H_SYN_B) && (w_h_nxt < H_SYN_E);
    w_flags_nxt.vs  = (w_v_nxt >= V_SYN_B) && (w_v_nxt < V_SYN_E);
    w_flags_nxt.fs  = (w_h_nxt == '0) && (w_v_nxt == '0);
    o_fetch_nxt     = w_flags_nxt.vis && (w_h_nxt[3:0] == 4'd0);
    o_origin_nxt    = w_flags_nxt.fs;
  end

  // Counter and flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_started <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_flags   <= '0;
    end else begin
      r_started <= 1'b1;
      r_h       <= w_h_nxt;
      r_v       <= w_v_nxt;
      r_flags   <= w_flags_nxt;
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/screen_scanout.sv
// Raster scan-out: walks the screen bitmap, fetches one word per 16 pixels, serialises LSB first.
// Latency: pixel/active/hsync/vsync/frame_start lag the raster counters (and rd_en) by 2 clocks.
// Backpressure: none; rdata must be valid the cycle after rd_en.
module screen_scanout
  import screen_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic             clock,
  input  logic             reset,
  screen_scanout_if.master bus
);

  logic        w_fetch_nxt;
  logic        w_origin_nxt;
  scan_flags_t w_s0;
  logic [12:0] w_addr;

  logic [12:0] r_raddr;
  logic [12:0] r_word;     // address of the next word to fetch
  logic        r_rd_en;
  scan_flags_t r_s1;
  logic        r_s1_load;  // rdata carries a fresh word this cycle
  scan_flags_t r_s2;
  logic [15:0] r_shift;
  logic        r_pixel;

  scan_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .o_fetch_nxt  (w_fetch_nxt),
    .o_origin_nxt (w_origin_nxt),
    .o_flags      (w_s0)
  );

  // Running word counter restarts at the frame origin; rows are contiguous so no multiply is needed.
  assign w_addr = w_origin_nxt ? 13'd0 : r_word;

  // Stage 0: issue the read for the position the counters are moving to; raddr holds between reads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_en <= 1'b0;
      r_raddr <= '0;
      r_word  <= '0;
    end else begin
      r_rd_en <= w_fetch_nxt;
      if (w_fetch_nxt) begin
        r_raddr <= w_addr;
        r_word  <= w_addr + 13'd1;
      end
    end
  end

  // Stage 1: carry position flags while the read is in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1      <= '0;
      r_s1_load <= 1'b0;
    end else begin
      r_s1      <= w_s0;
      r_s1_load <= r_rd_en;
    end
  end

  // Stage 2: serialise LSB first (leftmost pixel) and register all video outputs together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2    <= '0;
      r_shift <= '0;
      r_pixel <= 1'b0;
    end else begin
      r_s2 <= r_s1;
      if (r_s1_load) begin
        r_pixel <= r_s1.vis & bus.rdata[0];
        r_shift <= {1'b0, bus.rdata[15:1]};
      end else begin
        r_pixel <= r_s1.vis & r_shift[0];
        r_shift <= {1'b0, r_shift[15:1]};
      end
    end
  end

  assign bus.raddr       = r_raddr;
  assign bus.rd_en       = r_rd_en;
  assign bus.pixel       = r_pixel;
  assign bus.active      = r_s2.vis;
  assign bus.hsync       = r_s2.hs;
  assign bus.vsync       = r_s2.vs;
  assign bus.frame_start = r_s2.fs;

endmodule

// File: tb/tb_screen_scanout.sv
// Self-checking bench for screen_scanout using a reduced raster so several frames fit in a short run.
// Latency: expected outputs are derived from the cycle index since reset release.
// Backpressure: none; the bench memory answers every read one clock later.
module tb_screen_scanout;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int WPR = HA / 16;
  localparam int NWORDS = WPR * VA;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  screen_scanout_if bus_if ();

  screen_scanout #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [15:0] mem [0:NWORDS-1];

  // Synchronous read port: data valid the cycle after rd_en.
  always @(posedge clock) begin
    if (bus_if.rd_en) bus_if.rdata <= mem[bus_if.raddr];
  end

  int checks = 0;
  int errors = 0;
  int exp_raddr;
  int rd_cnt;
  int last_fs;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string ph);
    chk({ph, "_raddr"}, int'(bus_if.raddr), 0);
    chk({ph, "_rd_en"}, int'(bus_if.rd_en), 0);
    chk({ph, "_pixel"}, int'(bus_if.pixel), 0);
    chk({ph, "_active"}, int'(bus_if.active), 0);
    chk({ph, "_hsync"}, int'(bus_if.hsync), 0);
    chk({ph, "_vsync"}, int'(bus_if.vsync), 0);
    chk({ph, "_frame_start"}, int'(bus_if.frame_start), 0);
  endtask

  // Reference: after the n-th edge out of reset the fetch stage shows raster position n-1
  // and the video outputs show position n-3; positions wrap by line and frame totals.
  task automatic check_cycle(input int n);
    int p0, p2, h, v;
    int e_rd, e_vis, e_hs, e_vs, e_fs, e_pix;
    logic [15:0] w;
    p0 = n - 1;
    h = p0 % HT;
    v = (p0 / HT) % VT;
    e_rd = (h < HA && v < VA && h % 16 == 0) ? 1 : 0;
    if (e_rd == 1) exp_raddr = v * WPR + h / 16;
    chk("rd_en", int'(bus_if.rd_en), e_rd);
    chk("raddr", int'(bus_if.raddr), exp_raddr);
    if (bus_if.rd_en) rd_cnt++;
    if (h == HT - 1 && v == VT - 1) begin
      chk("reads_per_frame", rd_cnt, NWORDS);
      rd_cnt = 0;
    end

    e_vis = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_pix = 0;
    p2 = n - 3;
    if (p2 >= 0) begin
      h = p2 % HT;
      v = (p2 / HT) % VT;
      e_vis = (h < HA && v < VA) ? 1 : 0;
      if (e_vis == 1) begin
        w = mem[v * WPR + h / 16];
        e_pix = int'(w[h % 16]);
      end
      e_hs = (h >= HA + HF && h < HA + HF + HS) ? 1 : 0;
      e_vs = (v >= VA + VF && v < VA + VF + VS) ? 1 : 0;
      e_fs = (h == 0 && v == 0) ? 1 : 0;
    end
    chk("pixel", int'(bus_if.pixel), e_pix);
    chk("active", int'(bus_if.active), e_vis);
    chk("hsync", int'(bus_if.hsync), e_hs);
    chk("vsync", int'(bus_if.vsync), e_vs);
    chk("frame_start", int'(bus_if.frame_start), e_fs);
    if (bus_if.frame_start) begin
      if (last_fs > 0) chk("frame_period", n - last_fs, FRAME);
      last_fs = n;
    end
  endtask

  task automatic run(input int ncyc);
    exp_raddr = 0;
    rd_cnt = 0;
    last_fs = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clock);
      @(negedge clock);
      check_cycle(n);
    end
  endtask

  // Assert reset between edges, hold for three edges, release mid-cycle.
  task automatic async_reset(input string ph);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_zero(ph);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = 16'($urandom);
    bus_if.rdata = 16'h0;

    // Random bitmap across two full frames and part of a third.
    #12 check_zero("reset");
    #10 reset = 1'b1;
    run(2 * FRAME + int'($urandom_range(100, 600)));

    // Mid-frame reset, then alternating pattern to expose word-boundary glitches.
    async_reset("midreset");
    for (int i = 0; i < NWORDS; i++) mem[i] = 16'hAAAA;
    run(FRAME + 20);

    // Single set pixels: (0,0) and column 31 of line 1.
    async_reset("reset2");
    for (int i = 0; i < NWORDS; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    mem[WPR + 1] = 16'h8000;
    run(FRAME + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_scanout.md
# screen_scanout

Raster scan-out engine that consumes the 8K-word screen region of data memory and turns it into a serial pixel stream with horizontal/vertical sync. It sits downstream of the memory block. It reads the screen RAM through a dedicated read port: the CPU keeps the existing write port and the scan-out path never writes. It repeatedly walks the 512x256 bitmap in Hack screen order, one pixel per clock, and inserts blanking and sync intervals between lines and frames.

## Interface
Parameters:
- H_ACTIVE, 512: visible pixels per line; multiple of 16.
- H_FRONT, 16: front-porch clocks after the visible part of a line.
- H_SYNC, 32: hsync pulse clocks.
- H_BACK, 16: back-porch clocks.
- V_ACTIVE, 256: visible lines.
- V_FRONT, 2: front-porch lines.
- V_SYNC, 4: vsync pulse lines.
- V_BACK, 2: back-porch lines.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- raddr  out  13  screen RAM word address.
- rd_en  out  1  read strobe. Data is valid on `rdata` the cycle after `rd_en`=1.
- rdata  in  16  screen RAM read data. Must be valid exactly 1 cycle after the read is issued.
- pixel  out  1  current pixel. 1 = black. Forced to 0 when `active`=0.
- active  out  1  1 while a visible pixel is presented.
- hsync  out  1  active-high horizontal sync.
- vsync  out  1  active-high vertical sync.
- frame_start  out  1  one-cycle pulse that coincides with the output of pixel (0,0).

## Operation
- Timing counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (576 with defaults).
  - v counts 0..V_TOTAL-1, where V_TOTAL = 264 with defaults.
  - v increments when h wraps to 0. v wraps to 0 after V_TOTAL-1.
- Visible region: h < H_ACTIVE and v < V_ACTIVE.
- Fetch:
  - When visible and h[3:0]==0, assert rd_en with raddr = v*(H_ACTIVE/16) + h/16.
  - Implement the address with a running word counter, not a multiplier.
  - The word counter resets to 0 at v=0,h=0.
  - Outside the visible region, rd_en=0 and raddr holds its last value.
- Serialiser:
  - On the cycle rdata returns, bit 0 goes to pixel and bits 15:1 load a 16-bit shift register.
  - Each following cycle shifts right by one.
  - Pixel column c therefore maps to bit c%16 of its word (LSB = leftmost), matching the CPU's screen convention.
- Sync windows:
  - hsync=1 while H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync=1 likewise on v, using the V_* parameters.
- Arithmetic:
  - H_ACTIVE/16*V_ACTIVE must not exceed 8192; the word counter is 13 bits.
  - Counters are sized with $clog2 of the totals.
- Reset, asserted at any time including mid-line:
  - h=0, v=0, word counter 0, shift register 0.
  - raddr=0, rd_en=0, pixel=0, active=0, hsync=0, vsync=0, frame_start=0.
  - Any in-flight read is discarded.
- No backpressure: rdata is trusted. Screen writes by the CPU during scan-out may tear; this is accepted.

## Timing
- Pipeline:
  - Stage 0: counters, and rd_en/raddr from combinational decode of the counters, registered out.
  - Stage 1: rdata arrives.
  - Stage 2: pixel, active, hsync, vsync and frame_start are registered outputs.
- All stage-2 outputs describe the same (h,v) and lag the counters by exactly 2 clocks.
- After reset deasserts, counters are at (0,0) on the first edge:
  - rd_en=1 with raddr=0 on that cycle.
  - frame_start and the first active pixel appear 2 cycles later.
- Each line takes H_TOTAL clocks and each frame takes H_TOTAL*V_TOTAL clocks (152064 with defaults).
- rd_en fires once every 16 clocks during visible h: 32 reads per line, 8192 per frame.
- Line wrap: the last word of line y (raddr y*32+31) is issued at h=496. The next read is at h=0 of line y+1.
- Frame wrap: after line 255 no reads occur until v wraps to 0, where raddr returns to 0.

## Structure
- Shared include `screen_defs.vh` holds:
  - SCREEN_BASE (15'h4000)
  - SCREEN_WORDS (8192)
  - default H_*/V_* constants
  - WORDS_PER_ROW (32)
- Memory and this block both use `screen_defs.vh`.
- One sub-module, `scan_timing`, owns the h/v counters, visible/sync decode and the frame_start decode.
- `screen_scanout` owns fetch address generation, the shift register and the 2-stage output alignment.
- Memory gains a second read port on RAM8K for `raddr`/`rdata`.

## Test plan
- Memory model all zeros except word 0 = 16'h0001, reset released → frame_start and pixel=1 together; the next 15 pixels are 0; active=1 for exactly 512 consecutive cycles.
- Word 33 = 16'h8000 → on line 1 only pixel column 31 is 1, appearing H_TOTAL+31+2 clocks after the first rd_en.
- Count over one full frame → exactly 8192 rd_en pulses, raddr sequence 0..8191 with no gaps, and frame_start repeats every 152064 clocks.
- Check sync windows → hsync high exactly 32 clocks per line, starting 528 clocks after active rises; vsync high for 4*576 clocks starting at line 258; pixel=0 whenever active=0.
- Assert reset at line 100, h=200 for 3 cycles, asynchronously between edges → all outputs 0 within the same cycle; after release, raddr=0 and frame_start is seen 2 clocks later.
- Fill the pattern with 16'hAAAA → the pixel stream alternates 0,1,0,1 across every word boundary with no glitch at h multiples of 16.
